// File: rtl/max7219.sv
// Write-only serial master for a MAX7219 LED driver: one 16-bit register
// write per strobe, shifted MSB-first and latched with a LOAD pulse.
module max7219 #(
    parameter int CLK_HALF_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stb,
    output logic       o_busy,
    output logic       o_ack,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_serial_din,
    output logic       o_serial_dout,
    output logic       o_serial_load,
    output logic       o_serial_clk
);

    localparam int CW = $clog2(2 * CLK_HALF_CYCLES + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(2 * CLK_HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   frame;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] tick;
    logic          phase;
    logic          half_end;
    logic          load_end;
    logic          last_bit;
    logic          unused_din;

    // The chip's daisy-chain return is not needed by a single-chip master.
    assign unused_din = i_serial_din;

    assign half_end = (tick == HALF_LAST);
    assign load_end = (tick == LOAD_LAST);
    assign last_bit = (bit_cnt == 4'd15);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_stb) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (half_end && phase && last_bit) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (load_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // phase=0 is the low half of a bit cell, phase=1 the high half; the
    // frame advances only as the high half ends, so DIN never moves on a rise.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            frame   <= '0;
            bit_cnt <= '0;
            tick    <= '0;
            phase   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tick  <= '0;
                    phase <= 1'b0;
                    if (i_stb) begin
                        frame   <= {4'b0000, i_addr, i_data};
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        tick  <= '0;
                        phase <= ~phase;
                        if (phase) begin
                            frame   <= {frame[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                LOAD: begin
                    phase <= 1'b0;
                    if (load_end) begin
                        tick <= '0;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    tick  <= '0;
                    phase <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_busy        = 1'b0;
        o_ack         = 1'b0;
        o_serial_dout = 1'b0;
        o_serial_clk  = 1'b0;
        o_serial_load = 1'b0;
        unique case (state)
            SHIFT: begin
                o_busy        = 1'b1;
                o_serial_dout = frame[15];
                o_serial_clk  = phase;
            end
            LOAD: begin
                o_busy        = 1'b1;
                o_serial_load = 1'b1;
            end
            DONE: begin
                o_ack = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_max7219.sv
// Bench for max7219: a behavioural MAX7219 chip model decodes the serial
// stream into registers; digits are read back through a 7-segment decoder.
module tb_max7219;

    localparam int H        = 1;
    localparam int FALL_AT  = 32 * H + 2 * H;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         digit;
        int         bcd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb;
    logic [3:0] addr;
    logic [7:0] data;
    logic       din;
    logic       busy;
    logic       ack;
    logic       sdout;
    logic       sload;
    logic       sclk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_reg [16] = '{default: 8'h00};

    always #5 clk = ~clk;

    max7219 #(.CLK_HALF_CYCLES(H)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_stb(stb),
        .o_busy(busy),
        .o_ack(ack),
        .i_addr(addr),
        .i_data(data),
        .i_serial_din(din),
        .o_serial_dout(sdout),
        .o_serial_load(sload),
        .o_serial_clk(sclk)
    );

    // chip model: 16-bit shift register, latched on LOAD rising edge
    logic [15:0] chip_sr = 16'h0000;
    logic [7:0]  chip_reg [16] = '{default: 8'h00};
    logic [15:0] last_frame = 16'h0000;
    int          clk_edges = 0;
    int          load_edges = 0;
    int          edges_at_load = 0;

    always @(posedge sclk) begin
        chip_sr   <= {chip_sr[14:0], sdout};
        clk_edges <= clk_edges + 1;
    end

    always @(posedge sload) begin
        chip_reg[chip_sr[11:8]] <= chip_sr[7:0];
        last_frame              <= chip_sr;
        edges_at_load           <= clk_edges;
        load_edges              <= load_edges + 1;
    end

    function automatic logic [6:0] codeb(input logic [3:0] v);
        case (v)
            4'h0: return 7'h7E;
            4'h1: return 7'h30;
            4'h2: return 7'h6D;
            4'h3: return 7'h79;
            4'h4: return 7'h33;
            4'h5: return 7'h5B;
            4'h6: return 7'h5F;
            4'h7: return 7'h70;
            4'h8: return 7'h7F;
            4'h9: return 7'h7B;
            4'hA: return 7'h01;
            4'hB: return 7'h4F;
            4'hC: return 7'h37;
            4'hD: return 7'h0E;
            4'hE: return 7'h67;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int seg2bcd(input logic [6:0] s);
        for (int v = 0; v < 10; v++) begin
            if (codeb(4'(v)) == s) return v;
        end
        return 15;
    endfunction

    function automatic int digit(input int i);
        logic [7:0] r;
        logic [6:0] s;
        r = chip_reg[i + 1];
        s = chip_reg[9][i] ? codeb(r[3:0]) : r[6:0];
        return seg2bcd(s);
    endfunction

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Called at #1 after the accepting edge; returns at the DONE cycle.
    task automatic wait_frame(input string tag, input logic [15:0] frm);
        int   n;
        int   load_cyc;
        int   clkhi_cyc;
        int   e0;
        int   l0;
        logic done;
        e0        = clk_edges;
        l0        = load_edges;
        n         = 0;
        load_cyc  = 0;
        clkhi_cyc = 0;
        done      = 1'b0;
        check({tag, "/busy_rise"}, int'(busy), 1);
        while (n < 64 && !done) begin
            if (sload) load_cyc++;
            if (sclk) clkhi_cyc++;
            @(posedge clk);
            #1;
            n++;
            if (!busy) done = 1'b1;
        end
        check({tag, "/busy_fall_cycle"}, n, FALL_AT);
        check({tag, "/ack_at_fall"}, int'(ack), 1);
        check({tag, "/clk_edges"}, clk_edges - e0, 16);
        check({tag, "/clk_high_cycles"}, clkhi_cyc, 16 * H);
        check({tag, "/load_pulses"}, load_edges - l0, 1);
        check({tag, "/load_cycles"}, load_cyc, 2 * H);
        check({tag, "/load_after_last_edge"}, edges_at_load - e0, 16);
        check({tag, "/frame"}, int'(last_frame), int'(frm));
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                            input string tag);
        addr = a;
        data = d;
        stb  = 1'b1;
        @(posedge clk);
        #1;
        stb  = 1'b0;
        addr = 4'($urandom);
        data = 8'($urandom);
        wait_frame(tag, {4'b0000, a, d});
        exp_reg[a] = d;
        @(posedge clk);
        #1;
        check({tag, "/ack_one_cycle"}, int'({ack, busy, sdout}), 0);
    endtask

    vec_t vecs [18];
    int   act;

    initial begin
        rst  = 1'b1;
        stb  = 1'b0;
        addr = 4'h0;
        data = 8'h00;
        din  = 1'b0;
        #12;
        check("reset_outputs", int'({busy, ack, sdout, sclk, sload}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            act = act | int'({busy, ack, sdout, sclk, sload});
        end
        check("idle_activity", act, 0);
        check("idle_edges", clk_edges + load_edges, 0);

        vecs[0] = '{4'h9, 8'hFF, -1, 0};
        vecs[1] = '{4'hA, 8'h07, -1, 0};
        vecs[2] = '{4'hB, 8'h05, -1, 0};
        vecs[3] = '{4'hC, 8'h01, -1, 0};
        for (int i = 0; i < 6; i++) begin
            vecs[4 + i] = '{4'(i + 1), 8'(i), i, i};
        end
        for (int i = 0; i < 4; i++) begin
            vecs[10 + i] = '{4'(i + 1), 8'(i + 6), i, i + 6};
        end
        for (int i = 0; i < 4; i++) begin
            vecs[14 + i] = '{4'h0, 8'h00, -1, 0};
        end
        for (int i = 0; i < 14; i++) begin
            do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
            if (vecs[i].digit >= 0) begin
                check($sformatf("vec%0d/digit%0d", i, vecs[i].digit),
                      digit(vecs[i].digit), vecs[i].bcd);
            end
        end
        check("digit4_kept", digit(4), 4);
        check("digit5_kept", digit(5), 5);

        do_write(4'hA, 8'h07, "wave");
        check("wave_bits", int'(last_frame), 16'h0A07);

        // reset in the middle of a shift
        addr = 4'h3;
        data = 8'h02;
        stb  = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        act = load_edges;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("midreset_outputs", int'({busy, ack, sdout, sclk, sload}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_no_load", load_edges - act, 0);
        check("midreset_digit2", digit(2), 8);
        @(posedge clk);
        #1;
        do_write(4'h3, 8'h05, "after_reset");
        check("after_reset_digit2", digit(2), 5);

        // strobe held high: one IDLE cycle after DONE, then a new frame
        addr = 4'h7;
        data = 8'h44;
        stb  = 1'b1;
        @(posedge clk);
        #1;
        addr = 4'h8;
        data = 8'h09;
        wait_frame("held1", 16'h0744);
        exp_reg[7] = 8'h44;
        @(posedge clk);
        #1;
        check("held/idle_gap", int'({busy, ack}), 0);
        @(posedge clk);
        #1;
        stb  = 1'b0;
        addr = 4'h1;
        data = 8'hEE;
        wait_frame("held2", 16'h0809);
        exp_reg[8] = 8'h09;
        @(posedge clk);
        #1;
        check("held/reg7", int'(chip_reg[7]), 8'h44);
        check("held/digit7", digit(7), 9);

        for (int i = 0; i < 30; i++) begin
            logic [3:0] a;
            logic [7:0] d;
            a = 4'($urandom_range(1, 15));
            d = 8'($urandom);
            do_write(a, d, $sformatf("rnd%0d", i));
            check($sformatf("rnd%0d/reg", i), int'(chip_reg[a]), int'(d));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        for (int r = 1; r < 16; r++) begin
            check($sformatf("final_reg%0d", r), int'(chip_reg[r]),
                  int'(exp_reg[r]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
